// File: rtl/imem_stream_loader.sv
// Instruction-memory loader: takes a byte stream (16-bit word count, then big-endian 32-bit
// words) and writes each word to consecutive instruction-memory addresses, holding the CPU.
module imem_stream_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        in_valid_i,
  input  logic [7:0]  in_byte_i,
  output logic        in_ready_o,
  output logic        im_we_o,
  output logic [31:0] im_addr_o,
  output logic [31:0] im_wd_o,
  output logic        cpu_hold_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        overflow_o,
  output logic [15:0] words_wr_o
);

  localparam int unsigned Depth = 1 << ADDR_W;

  typedef enum logic [2:0] {
    StIdle, StLenHi, StLenLo, StData, StWrite, StFin
  } state_e;

  state_e              state_q;
  logic [15:0]         len_q;
  logic [15:0]         words_wr_q;
  logic [1:0]          byte_idx_q;
  logic [23:0]         word_q;
  logic [31:0]         im_wd_q;
  logic [ADDR_W-1:0]   im_addr_q;
  logic                overflow_q;
  logic                xfer;
  logic                full;

  assign xfer = in_valid_i & in_ready_o;
  // Memory is full once the next address would fall past the last word.
  assign full = 32'(words_wr_q) >= Depth;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      len_q      <= '0;
      words_wr_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      im_wd_q    <= '0;
      im_addr_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q    <= StLenHi;
            words_wr_q <= '0;
            overflow_q <= 1'b0;
            byte_idx_q <= '0;
          end
        end
        StLenHi: begin
          if (xfer) begin
            len_q[15:8] <= in_byte_i;
            state_q     <= StLenLo;
          end
        end
        StLenLo: begin
          if (xfer) begin
            len_q[7:0] <= in_byte_i;
            state_q    <= ({len_q[15:8], in_byte_i} == 16'd0) ? StFin : StData;
          end
        end
        StData: begin
          if (xfer) begin
            // Bytes arrive MSB first, so shifting left lands byte 0 in [31:24].
            word_q     <= {word_q[15:0], in_byte_i};
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              state_q <= StWrite;
              if (!full) begin
                im_wd_q   <= {word_q, in_byte_i};
                im_addr_q <= words_wr_q[ADDR_W-1:0];
              end
            end
          end
        end
        StWrite: begin
          if (full) overflow_q <= 1'b1;
          words_wr_q <= words_wr_q + 16'd1;
          state_q    <= (words_wr_q + 16'd1 == len_q) ? StFin : StData;
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign in_ready_o = (state_q == StLenHi) || (state_q == StLenLo) || (state_q == StData);
  assign im_we_o    = (state_q == StWrite) && !full;
  assign im_addr_o  = {{(32 - ADDR_W){1'b0}}, im_addr_q};
  assign im_wd_o    = im_wd_q;
  assign cpu_hold_o = (state_q != StIdle);
  assign busy_o     = (state_q != StIdle);
  assign done_o     = (state_q == StFin);
  assign overflow_o = overflow_q;
  assign words_wr_o = words_wr_q;

endmodule
